// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared opcode/state types and saturating accumulate helper
package accel_pkg;

    typedef enum logic [1:0] {
        OP_COS_FT  = 2'd0,
        OP_COS_FX  = 2'd1,
        OP_COS_ACC = 2'd2,
        OP_ACC_RD  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] ACC_SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] ACC_SAT_MIN = 32'h8000_0000;

    // Overflow only when both operands share a sign that the sum does not.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
        if (!a[31] && !b[31] && s[31]) begin
            return ACC_SAT_MAX;
        end
        if (a[31] && b[31] && !s[31]) begin
            return ACC_SAT_MIN;
        end
        return s;
    endfunction

endpackage

// File: rtl/accel_seq.sv
// rtl/accel_seq.sv - Nios II custom-instruction sequencer for the cosine datapath
module accel_seq #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [1:0]  n,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] dp_x_ft,
    input  logic [23:0] dp_y_fx,
    input  logic [31:0] dp_y_ft
);
    import accel_pkg::*;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [31:0] acc;
    logic [31:0] op_reg;
    op_t         n_reg;
    logic [31:0] fx_ext;
    logic [31:0] acc_sum;

    assign fx_ext  = {{8{dp_y_fx[23]}}, dp_y_fx};
    assign acc_sum = sat_add(acc, fx_ext);
    assign dp_x_ft = op_reg;
    // Gated by rst so an aborted instruction never shows a completion.
    assign done    = (state == RESP) && clk_en && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (op_t'(n) == OP_ACC_RD) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 4'd0;
            acc    <= 32'd0;
            result <= 32'd0;
            op_reg <= 32'd0;
            n_reg  <= OP_COS_FT;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_reg <= dataa;
                        n_reg  <= op_t'(n);
                        cnt    <= CNT_INIT;
                        if (op_t'(n) == OP_ACC_RD) begin
                            result <= acc;
                            acc    <= 32'd0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        case (n_reg)
                            OP_COS_FT: result <= dp_y_ft;
                            OP_COS_FX: result <= fx_ext;
                            OP_COS_ACC: begin
                                acc    <= acc_sum;
                                result <= acc_sum;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_seq.sv
// tb/tb_accel_seq.sv - self-checking bench for accel_seq
module tb_accel_seq;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [1:0]  n;
    logic        done;
    logic [31:0] result;
    logic [31:0] dp_x_ft;
    logic [23:0] dp_y_fx;
    logic [31:0] dp_y_ft;

    int checks = 0;
    int errors = 0;
    longint m_acc = 0;

    accel_seq #(.LATENCY(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .start   (start),
        .dataa   (dataa),
        .n       (n),
        .done    (done),
        .result  (result),
        .dp_x_ft (dp_x_ft),
        .dp_y_fx (dp_y_fx),
        .dp_y_ft (dp_y_ft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [23:0] fx;
        logic [31:0] ft;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: cosine results by opcode, accumulator clamped to the int32 range.
    task automatic model_step(input logic [1:0] op, input logic [23:0] fx, input logic [31:0] ft,
                              output logic [31:0] exp_res);
        longint v;
        v = longint'(fx);
        if (v >= 64'sd8388608) v = v - 64'sd16777216;
        exp_res = 32'd0;
        case (op)
            2'd0: exp_res = ft;
            2'd1: exp_res = 32'(v);
            2'd2: begin
                m_acc = m_acc + v;
                if (m_acc > 64'sd2147483647) m_acc = 64'sd2147483647;
                if (m_acc < -64'sd2147483648) m_acc = -64'sd2147483648;
                exp_res = 32'(m_acc);
            end
            default: begin
                exp_res = 32'(m_acc);
                m_acc = 0;
            end
        endcase
    endtask

    task automatic exec(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [23:0] fx, input logic [31:0] ft,
                        input logic [31:0] exp_res, input int exp_lat);
        int lat;
        logic [31:0] res;
        logic [31:0] x;
        lat = -1;
        res = 32'hDEAD_BEEF;
        x = 32'd0;
        start = 1'b1;
        n = op;
        dataa = a;
        dp_y_fx = fx;
        dp_y_ft = ft;
        for (int i = 1; i <= 40; i++) begin
            tick();
            start = 1'b0;
            if (i == 1) x = dp_x_ft;
            if (done) begin
                lat = i;
                res = result;
                break;
            end
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_res"}, res, exp_res);
        check({name, "_dpx"}, x, a);
        tick();
        check({name, "_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic run_model(input string name, input logic [1:0] op, input logic [31:0] a,
                             input logic [23:0] fx, input logic [31:0] ft);
        logic [31:0] e;
        model_step(op, fx, ft, e);
        exec(name, op, a, fx, ft, e, (op == 2'd3) ? 1 : LAT + 1);
    endtask

    initial begin
        logic [31:0] e;
        int lat;
        int pulses;

        rst = 1'b1;
        clk_en = 1'b1;
        start = 1'b0;
        dataa = 32'd0;
        n = 2'd0;
        dp_y_fx = 24'd0;
        dp_y_ft = 32'd0;
        tick();
        tick();
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_dpx", dp_x_ft, 32'd0);
        rst = 1'b0;
        tick();

        vecs[0] = '{2'd0, 32'h0000_0000, 24'h000000, 32'h3F80_0000, 32'h3F80_0000, 5};
        vecs[1] = '{2'd1, 32'h3F00_0000, 24'hC00000, 32'h1234_5678, 32'hFFC0_0000, 5};
        vecs[2] = '{2'd3, 32'h0000_0011, 24'h000000, 32'h0000_0000, 32'h0000_0000, 1};
        vecs[3] = '{2'd2, 32'h4000_0000, 24'h400000, 32'h0000_0000, 32'h0040_0000, 5};
        vecs[4] = '{2'd2, 32'h4000_0001, 24'h400000, 32'h0000_0000, 32'h0080_0000, 5};
        vecs[5] = '{2'd2, 32'h4000_0002, 24'h400000, 32'h0000_0000, 32'h00C0_0000, 5};
        vecs[6] = '{2'd3, 32'h0000_0022, 24'h000000, 32'h0000_0000, 32'h00C0_0000, 1};
        vecs[7] = '{2'd3, 32'h0000_0033, 24'h000000, 32'h0000_0000, 32'h0000_0000, 1};
        vecs[8] = '{2'd1, 32'hC0490FDB, 24'h7FFFFF, 32'h0000_0000, 32'h007F_FFFF, 5};
        for (int i = 0; i < 9; i++) begin
            model_step(vecs[i].op, vecs[i].fx, vecs[i].ft, e);
            exec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].fx, vecs[i].ft,
                 vecs[i].exp_res, vecs[i].exp_lat);
        end

        for (int i = 0; i < 40; i++) begin
            run_model($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), $urandom,
                      24'($urandom), $urandom);
        end
        run_model("rnd_clear", 2'd3, 32'd0, 24'd0, 32'd0);

        for (int i = 0; i < 255; i++) begin
            run_model("sat_pos_fill", 2'd2, 32'd1, 24'h7FFFFF, 32'd0);
        end
        model_step(2'd2, 24'h7FFFFF, 32'd0, e);
        exec("sat_pos_near", 2'd2, 32'd2, 24'h7FFFFF, 32'd0, 32'h7FFF_FF00, LAT + 1);
        model_step(2'd2, 24'h7FFFFF, 32'd0, e);
        exec("sat_pos_clamp", 2'd2, 32'd3, 24'h7FFFFF, 32'd0, 32'h7FFF_FFFF, LAT + 1);
        model_step(2'd2, 24'h7FFFFF, 32'd0, e);
        exec("sat_pos_hold", 2'd2, 32'd4, 24'h7FFFFF, 32'd0, 32'h7FFF_FFFF, LAT + 1);
        model_step(2'd3, 24'd0, 32'd0, e);
        exec("sat_pos_read", 2'd3, 32'd5, 24'd0, 32'd0, 32'h7FFF_FFFF, 1);

        for (int i = 0; i < 256; i++) begin
            run_model("sat_neg_fill", 2'd2, 32'd6, 24'h800000, 32'd0);
        end
        model_step(2'd2, 24'h800000, 32'd0, e);
        exec("sat_neg_clamp", 2'd2, 32'd7, 24'h800000, 32'd0, 32'h8000_0000, LAT + 1);
        model_step(2'd3, 24'd0, 32'd0, e);
        exec("sat_neg_read", 2'd3, 32'd8, 24'd0, 32'd0, 32'h8000_0000, 1);

        // Stall three cycles mid-BUSY and pulse start while busy.
        start = 1'b1;
        n = 2'd0;
        dataa = 32'h4049_0FDB;
        dp_y_ft = 32'hBF80_0000;
        lat = -1;
        pulses = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            start = (i == 6);
            clk_en = !(i >= 2 && i <= 4);
            if (done) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        check("stall_lat", 32'(lat), 32'(LAT + 1 + 3));
        check("stall_pulses", 32'(pulses), 32'd1);
        check("stall_res", result, 32'hBF80_0000);

        // done is suppressed while clk_en is low in RESP.
        start = 1'b1;
        n = 2'd3;
        tick();
        start = 1'b0;
        clk_en = 1'b0;
        #1;
        check("resp_gated", 32'(done), 32'd0);
        clk_en = 1'b1;
        #1;
        check("resp_open", 32'(done), 32'd1);
        tick();
        check("resp_after", 32'(done), 32'd0);
        m_acc = 0;

        // Reset in BUSY during an accumulate aborts it.
        run_model("pre_acc", 2'd2, 32'd9, 24'h123456, 32'd0);
        start = 1'b1;
        n = 2'd2;
        dp_y_fx = 24'h100000;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            start = 1'b0;
            rst = (i == 2);
            if (done) pulses++;
        end
        m_acc = 0;
        check("rst_busy_pulses", 32'(pulses), 32'd0);
        check("rst_busy_result", result, 32'd0);
        run_model("rst_busy_acc", 2'd3, 32'd10, 24'd0, 32'd0);
        run_model("rst_busy_next", 2'd0, 32'h3F00_0000, 24'd0, 32'h3F5A_8279);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
